// File: rtl/conv1_relu_maxpool_pkg.sv
// Shared constants for the first CNN layer and the pooling stage.
package conv1_relu_maxpool_pkg;

    // Layer dimensions shared across the CNN datapath
    localparam int CONV1_OUT_W   = 24;
    localparam int CONV1_OUT_H   = 24;
    localparam int CONV1_CH      = 3;
    localparam int CONV_ACC_BITS = 12;
    localparam int POOL1_OUT_W   = CONV1_OUT_W / 2;
    localparam int POOL1_OUT_H   = CONV1_OUT_H / 2;

    // Address width helper that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv1_relu_maxpool_half_row_buf.sv
// Half-row buffer: holds the horizontal max of each even-row pixel pair
// until the matching odd-row pair arrives. Synchronous write, async read,
// no reset (every entry is written before it is read).
module pool_half_row_buf #(
    parameter int DEPTH     = 12,
    parameter int DATA_BITS = 12,
    parameter int AW        = 4
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // Store the even-row horizontal max at its pair slot
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv1_relu_maxpool.sv
// ReLU + 2x2 stride-2 max pooling on the 3-channel conv1 stream.
// One half-row buffer per channel; output strobes one cycle after the
// bottom-right pixel of each window.
// Optional: define CONV1_POOL_FRAME_DONE_EN to add a frame_done pulse
// aligned with the last window's valid_out.
module conv1_relu_maxpool
    import conv1_relu_maxpool_pkg::*;
#(
    parameter int IN_WIDTH  = CONV1_OUT_W,
    parameter int IN_HEIGHT = CONV1_OUT_H,
    parameter int DATA_BITS = CONV_ACC_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] conv_in_1,
    input  logic [DATA_BITS-1:0] conv_in_2,
    input  logic [DATA_BITS-1:0] conv_in_3,
    output logic [DATA_BITS-1:0] pool_out_1,
    output logic [DATA_BITS-1:0] pool_out_2,
    output logic [DATA_BITS-1:0] pool_out_3,
    output logic                 valid_out
`ifdef CONV1_POOL_FRAME_DONE_EN
    ,
    output logic                 frame_done
`endif
);

    localparam int NCH  = CONV1_CH;
    localparam int HALF = IN_WIDTH / 2;
    localparam int CW   = clog2_min1(IN_WIDTH);
    localparam int RW   = clog2_min1(IN_HEIGHT);
    localparam int AW   = clog2_min1(HALF);

    if ((IN_WIDTH % 2) != 0) begin : g_bad_width
        $error("conv1_relu_maxpool: IN_WIDTH must be even");
    end
    if ((IN_HEIGHT % 2) != 0) begin : g_bad_height
        $error("conv1_relu_maxpool: IN_HEIGHT must be even");
    end

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q;

    logic [NCH-1:0][DATA_BITS-1:0] x, r, h, p, buf_rd;
    logic [NCH-1:0][DATA_BITS-1:0] left_q, pool_q;

    logic          last_col, last_row, win_done, buf_we;
    logic [AW-1:0] buf_addr;

    assign x        = {conv_in_3, conv_in_2, conv_in_1};
    assign last_col = (col_q == CW'(IN_WIDTH - 1));
    assign last_row = (row_q == RW'(IN_HEIGHT - 1));
    // Odd column on odd row = bottom-right pixel of a 2x2 window
    assign win_done = valid_in & col_q[0] & row_q[0];
    assign buf_we   = valid_in & col_q[0] & ~row_q[0];
    assign buf_addr = AW'(col_q >> 1);

    // Per-channel ReLU, horizontal max, vertical max and row buffer
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign r[c] = x[c][DATA_BITS-1] ? '0 : x[c];
        assign h[c] = (left_q[c] >= r[c]) ? left_q[c] : r[c];
        assign p[c] = (h[c] >= buf_rd[c]) ? h[c] : buf_rd[c];

        pool_half_row_buf #(
            .DEPTH    (HALF),
            .DATA_BITS(DATA_BITS),
            .AW       (AW)
        ) u_buf (
            .clk    (clk),
            .we_i   (buf_we),
            .addr_i (buf_addr),
            .wdata_i(h[c]),
            .rdata_o(buf_rd[c])
        );
    end

    // Raster position: advance on accepted pixels, wrap at row/frame end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Counters, left-pixel capture and pooled output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            left_q  <= '0;
            pool_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= win_done;
            if (valid_in && !col_q[0]) left_q <= r;
            if (win_done)              pool_q <= p;
        end
    end

    assign pool_out_1 = pool_q[0];
    assign pool_out_2 = pool_q[1];
    assign pool_out_3 = pool_q[2];
    assign valid_out  = valid_q;

`ifdef CONV1_POOL_FRAME_DONE_EN
    logic frame_done_q;

    // Pulse alongside the strobe of the final window in the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_done_q <= 1'b0;
        else     frame_done_q <= win_done & last_col & last_row;
    end

    assign frame_done = frame_done_q;
`endif

endmodule

// File: doc/conv1_relu_maxpool.md
Name: conv1_relu_maxpool

Overview:
- Stage directly downstream of the first-layer convolution sum unit.
- Consumes the 3-channel signed 12-bit convolution stream (24x24 raster, one pixel per valid strobe).
- Applies ReLU, then 2x2 stride-2 max pooling per channel, producing a 12x12x3 stream for the second convolution stage's window buffer.
- Uses one half-row buffer per channel; no frame storage.

Parameters:
- IN_WIDTH, 24, pixels per input row; must be even; elaboration error otherwise.
- IN_HEIGHT, 24, input rows per frame; must be even; elaboration error otherwise.
- DATA_BITS, 12, width of each signed channel sample in and out.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  qualifies conv_in_1..3 this cycle.
- conv_in_1  input  DATA_BITS  channel 1 convolution result, signed two's complement.
- conv_in_2  input  DATA_BITS  channel 2, signed.
- conv_in_3  input  DATA_BITS  channel 3, signed.
- pool_out_1  output  DATA_BITS  channel 1 pooled value, signed, always >= 0.
- pool_out_2  output  DATA_BITS  channel 2 pooled value.
- pool_out_3  output  DATA_BITS  channel 3 pooled value.
- valid_out  output  1  one-cycle strobe qualifying pool_out_1..3.

Behaviour:
- Reset (async assert, sync release): pool_out_1..3 = 0; valid_out = 0; col/row counters = 0; left-pixel registers = 0.
  - Half-row buffer contents are don't-care after reset; they are always written before being read.
- ReLU: r = (x[DATA_BITS-1]) ? 0 : x, applied per channel on input. All later compares are unsigned on non-negative values.
- Counters:
  - col counts 0..IN_WIDTH-1. At IN_WIDTH-1 with valid_in, col wraps to 0 and row increments.
  - row counts 0..IN_HEIGHT-1. At last row/last col it wraps to 0 (next frame begins seamlessly).
  - valid_in low: counters and all state hold. Gaps of any length are allowed anywhere, including mid-pair.
- Per accepted pixel, per channel:
  - col even: store r in left register.
  - col odd: h = max(left, r).
    - If row even: write h to buf[col>>1].
    - If row odd: p = max(h, buf[col>>1]); register p to pool_out_n and assert valid_out on the next cycle.
- Latency: valid_out rises exactly 1 cycle after the valid_in that delivers the bottom-right pixel of each 2x2 window.
- Output rate: at most one valid_out per two accepted inputs. Per frame: (IN_WIDTH/2)*(IN_HEIGHT/2) = 144 strobes.
- valid_out is low in every other cycle. pool_out_n holds its last value when valid_out is low.
- Ties resolve to the equal value (no ordering significance).
- Reset mid-frame: partial windows are discarded. The next valid_in is treated as row 0, col 0.
- No backpressure. The downstream stage must accept every strobe.

Optional Feature:
- Macro: CONV1_POOL_FRAME_DONE_EN.
- Defined:
  - Adds output port frame_done (1 bit, reset 0).
  - frame_done pulses high for one cycle coincident with the valid_out of the final window (row IN_HEIGHT-1, col IN_WIDTH-1 input).
- Undefined:
  - Port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared constants include file (cnn_defs): CONV1_OUT_W=24, CONV1_OUT_H=24, CONV1_CH=3, CONV_ACC_BITS=12, POOL1_OUT_W=12, POOL1_OUT_H=12.
- One sub-module: pool_half_row_buf.
  - IN_WIDTH/2 x DATA_BITS register array.
  - Synchronous write, combinational read.
  - Instantiated once per channel.

Test Plan:
- Ramp frame, valid_in continuous, conv_in_1 = row*24+col (capped to 12-bit positive) -> 144 strobes; first pool_out_1 = 25, last = 575 (12-bit saturate check not applicable; values < 2047), every strobe exactly 1 cycle after an odd-row, odd-col input.
- ReLU check: window with conv_in_2 = {-5, -100, -1, -2048} -> pool_out_2 = 0; window with conv_in_3 = {-7, 3, -1, 2} -> pool_out_3 = 3.
- Random valid_in gaps (30% duty, including gaps between a pair's left and right pixels) on random signed data -> output sequence matches a golden ReLU + maxpool model bit-exactly; count = 144.
- Two back-to-back frames without idle -> 288 strobes; second frame results are unaffected by first-frame buffer contents.
- rst asserted after 100 accepted pixels, then a full frame -> outputs/valid_out go to 0 immediately, then exactly 144 strobes all matching the model.
- CONV1_POOL_FRAME_DONE_EN defined -> a single frame_done pulse per frame, aligned with the 144th valid_out; undefined -> build succeeds with no frame_done port.
